// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Loads one 512-bit padded block into a 16-word circular buffer and streams
// W[0..ROUNDS-1] over a valid/ready handshake. Words 16 and up are expanded
// on the fly from the buffer and written back over the oldest slot.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  logic [1:0]  state_q;
  logic [5:0]  t_q;
  logic [31:0] buf_q [16];

  // Buffer slot holding W[t-16]; also the slot W[t] is written into.
  logic [3:0]  slot;
  logic [31:0] w_m2, w_m7, w_m15, w_m16;
  logic [31:0] s0, s1;
  logic [31:0] w_new;
  logic [31:0] w_cur;
  logic        in_run;

  assign slot = t_q[3:0];

  // Taps are (t-k) mod 16; 4-bit arithmetic wraps naturally.
  assign w_m2  = buf_q[slot - 4'd2];
  assign w_m7  = buf_q[slot - 4'd7];
  assign w_m15 = buf_q[slot - 4'd15];
  assign w_m16 = buf_q[slot];

  // sigma0 / sigma1 as pure wiring: rotates are bit re-orderings, shifts zero-fill.
  assign s0 = {w_m15[6:0],  w_m15[31:7]}  ^ {w_m15[17:0], w_m15[31:18]} ^ {3'b0,  w_m15[31:3]};
  assign s1 = {w_m2[16:0],  w_m2[31:17]}  ^ {w_m2[18:0],  w_m2[31:19]}  ^ {10'b0, w_m2[31:10]};

  assign w_new = s1 + w_m7 + s0 + w_m16;
  assign w_cur = (t_q < 6'd16) ? buf_q[slot] : w_new;

  assign in_run  = (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign w_valid = in_run;
  assign done    = (state_q == DONE);
  assign w_idx   = in_run ? t_q   : 6'd0;
  assign w_out   = in_run ? w_cur : 32'd0;

  // FSM, word counter and circular buffer; everything advances only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      // NOTE: the buffer is cleared in reset so no stale block can leak out after
      // an abandoned run; 16 words is small enough that resetting them is cheap.
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every tap above reads the
      // pre-edge buffer contents even in the cycle a slot is overwritten.
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              buf_q[i] <= block_in[32*(15-i) +: 32];
            end
            t_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (w_ready) begin
            if (t_q >= 6'd16) begin
              buf_q[slot] <= w_new;
            end
            if (t_q == LAST_IDX) begin
              t_q     <= '0;
              state_q <= DONE;
            end else begin
              t_q <= t_q + 6'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Testbench for sha256_msg_sched: golden vectors, stall/start-poke/reset
// sequences, randomized blocks with random back-pressure, and a ROUNDS=16 instance.
module tb_sha256_msg_sched;

  logic         clk;
  logic         rst_n;
  logic         start, start16;
  logic [511:0] block_in, block16;
  logic         w_ready, ready16;
  logic         busy, w_valid, done;
  logic         busy16, valid16, done16;
  logic [31:0]  w_out, w_out16;
  logic [5:0]   w_idx, w_idx16;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model_w [64];
  logic [31:0] got_w   [64];

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready),
    .w_out(w_out), .w_idx(w_idx), .done(done)
  );

  sha256_msg_sched #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .block_in(block16),
    .busy(busy16), .w_valid(valid16), .w_ready(ready16),
    .w_out(w_out16), .w_idx(w_idx16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference schedule straight from FIPS 180-4: a flat 64-entry array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic sched(input logic [511:0] b);
    for (int i = 0; i < 16; i++) model_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      model_w[i] = (rotr(model_w[i-2], 17) ^ rotr(model_w[i-2], 19) ^ (model_w[i-2] >> 10))
                 + model_w[i-7]
                 + (rotr(model_w[i-15], 7) ^ rotr(model_w[i-15], 18) ^ (model_w[i-15] >> 3))
                 + model_w[i-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Runs one block on the 64-round DUT from the current negedge. stall_at: hold
  // ready low 5 cycles when that index is shown; poke_at: pulse start with
  // poke_blk there; abort_at: assert reset mid-cycle there and return.
  task automatic run64(input logic [511:0] blk, input int stall_at, input bit rand_ready,
                       input int poke_at, input logic [511:0] poke_blk, input int abort_at);
    int idx, stall_left, busy_cyc, holds;
    bit saw_done, stalled;
    sched(blk);
    block_in = blk; start = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; block_in = rand_block();
    idx = 0; stall_left = 0; busy_cyc = 0; holds = 0; saw_done = 0; stalled = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (busy) busy_cyc++;
      if (done || idx >= 64) begin
        saw_done = done;
        check("done_index", 32'(idx), 32'd64);
        check("valid_in_done", 32'(w_valid), 32'd0);
        break;
      end
      check($sformatf("w_valid[%0d]", idx), 32'(w_valid), 32'd1);
      check($sformatf("w_idx[%0d]", idx), 32'(w_idx), 32'(idx));
      check($sformatf("w_out[%0d]", idx), w_out, model_w[idx]);
      got_w[idx] = w_out;
      if (idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_w_valid", 32'(w_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_w_idx", 32'(w_idx), 32'd0);
        check("abort_w_out", w_out, 32'd0);
        return;
      end
      if (idx == stall_at && !stalled) begin
        stall_left = 5; stalled = 1;
      end
      if (stall_left > 0) begin
        w_ready = 1'b0; stall_left--;
      end else if (rand_ready) begin
        w_ready = 1'($urandom_range(0, 1));
      end else begin
        w_ready = 1'b1;
      end
      if (idx == poke_at) begin
        start = 1'b1; block_in = poke_blk;
      end else begin
        start = 1'b0; block_in = rand_block();
      end
      if (w_ready) idx++;
      else holds++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(saw_done), 32'd1);
    check("busy_cycles", 32'(busy_cyc), 32'(65 + holds));
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_w_valid", 32'(w_valid), 32'd0);
    check("idle_w_idx", 32'(w_idx), 32'd0);
    check("idle_w_out", w_out, 32'd0);
  endtask

  task automatic run16(input logic [511:0] blk);
    block16 = blk; start16 = 1'b1; ready16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; block16 = rand_block();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("r16_valid[%0d]", k), 32'(valid16), 32'd1);
      check($sformatf("r16_idx[%0d]", k), 32'(w_idx16), 32'(k));
      check($sformatf("r16_w[%0d]", k), w_out16, blk[511 - 32*k -: 32]);
      @(negedge clk);
    end
    check("r16_done", 32'(done16), 32'd1);
    check("r16_valid_done", 32'(valid16), 32'd0);
    @(negedge clk);
    check("r16_done_once", 32'(done16), 32'd0);
    check("r16_idle_busy", 32'(busy16), 32'd0);
  endtask

  typedef struct {
    logic [511:0] blk;
    int           idx;
    logic [31:0]  w;
  } vec_t;

  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ZERO = 512'h0;

  vec_t vecs [7];

  initial begin
    logic [511:0] b;
    vecs[0] = '{ABC,  0,  32'h61626380};
    vecs[1] = '{ABC,  15, 32'h00000018};
    vecs[2] = '{ABC,  16, 32'h61626380};
    vecs[3] = '{ABC,  17, 32'h000F0000};
    vecs[4] = '{ZERO, 0,  32'h00000000};
    vecs[5] = '{ZERO, 40, 32'h00000000};
    vecs[6] = '{ZERO, 63, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; start16 = 1'b0; w_ready = 1'b0; ready16 = 1'b0;
    block_in = '0; block16 = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_w_out", w_out, 32'd0);
    check("rst_w_idx", 32'(w_idx), 32'd0);
    check("rst16_busy", 32'(busy16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    // start is driven together with reset release: the first edge must accept it.
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run64(vecs[i].blk, -1, 1'b0, -1, '0, -1);
      check($sformatf("golden[%0d] W%0d", i, vecs[i].idx), got_w[vecs[i].idx], vecs[i].w);
    end

    // Back-pressure at W[20].
    run64(ABC, 20, 1'b0, -1, '0, -1);
    // start with a different block mid-run must be ignored.
    run64(ABC, -1, 1'b0, 10, rand_block(), -1);

    for (int r = 0; r < 5; r++) begin
      run64(rand_block(), -1, 1'b1, -1, '0, -1);
    end

    // Async reset mid-run, then restart with a fresh block.
    run64(rand_block(), -1, 1'b0, -1, '0, 30);
    @(negedge clk);
    rst_n = 1'b1;
    b = rand_block();
    run64(b, -1, 1'b0, -1, '0, -1);

    run16(rand_block());
    run16(ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 64: number of schedule words W[0..ROUNDS-1] emitted per block, legal range 16..64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to schedule block_in; sampled in IDLE only.
REQ-005 The block SHALL have port block_in, input, 512 bits: padded message block; W[0]=block_in[511:480], W[15]=block_in[31:0].
REQ-006 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-007 The block SHALL have port w_valid, output, 1 bit: w_out/w_idx hold a valid word.
REQ-008 The block SHALL have port w_ready, input, 1 bit: consumer accepts the word; transfer = w_valid & w_ready at a rising edge.
REQ-009 The block SHALL have port w_out, output, 32 bits: schedule word W[w_idx].
REQ-010 The block SHALL have port w_idx, output, 6 bits: index t of the current word.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final transfer.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL load block_in into a 16x32 circular buffer, set t=0, and enter RUN.
REQ-014 In RUN, w_valid SHALL be 1; w_idx SHALL equal t.
REQ-015 For t<16, w_out SHALL equal buffer slot t.
REQ-016 For t>=16, w_out SHALL equal sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32, all taken from buffer slots (t-k) mod 16.
REQ-017 sigma0(x) SHALL be ROTR7(x)^ROTR18(x)^SHR3(x); sigma1(x) SHALL be ROTR17(x)^ROTR19(x)^SHR10(x); rotations are true 32-bit circular rotates, combinational, with no added latency.
REQ-018 On a transfer with t>=16, w_out SHALL be written to slot t mod 16; on every transfer t SHALL increment by 1.
REQ-019 While w_valid=1 and w_ready=0, w_out and w_idx SHALL remain stable; no state SHALL change.
REQ-020 On the transfer of t=ROUNDS-1, the FSM SHALL enter DONE; w_valid SHALL be 0 in DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 start SHALL be ignored in RUN and DONE, and block_in SHALL be ignored outside the load edge.
REQ-023 With w_ready held at 1, words SHALL be emitted back-to-back, one per cycle: ROUNDS valid cycles starting the cycle after start, then one done cycle.
REQ-024 In IDLE, w_valid, done and busy SHALL be 0; w_out and w_idx SHALL be 0.

Reset
REQ-025 On rst_n=0, the block SHALL immediately, without a clock, enter IDLE, set t=0, clear all buffer slots, and drive busy=0, w_valid=0, done=0, w_out=0, w_idx=0.
REQ-026 Reset asserted mid-RUN SHALL abandon the block; the first start after reset release SHALL begin again at w_idx=0.
REQ-027 The first rising edge after rst_n rises SHALL be able to accept start.

Verification
REQ-028 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, all 64 words match the FIPS 180-4 golden model, done pulses once in the cycle after w_idx=63.
REQ-029 All-zero block -> 64 words of 0x00000000, w_idx 0..63 in order, busy high for 65 cycles.
REQ-030 w_ready=0 for 5 cycles while w_idx=20 -> w_out and w_idx unchanged for all 5 cycles; sequence then resumes at 20 with the correct value and no skips or repeats.
REQ-031 start pulsed at w_idx=10 with a different block_in -> ignored; the output stream is identical to the undisturbed run.
REQ-032 rst_n low asynchronously at w_idx=30 -> w_valid=0 and busy=0 before the next edge; a new start yields w_idx=0 and w_out=new W0.
REQ-033 ROUNDS=16 instance -> only buffer words are emitted (w_idx 0..15), then done; no expansion write occurs.
